// File: rtl/next_pc_btb_if.sv
// Fetch/EX-side signal bundle for the next-PC generator: current PC and
// branch resolution in, next PC, prediction, flush and debug count out.
interface next_pc_btb_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] pc;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_mispredict;
  logic [PC_W-1:0] pc_next;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            flush;
  logic [15:0]     mispredict_cnt;

  modport master (
    output pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_mispredict,
    input  pc_next, pred_taken, pred_target, flush, mispredict_cnt
  );

  modport slave (
    input  pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_mispredict,
    output pc_next, pred_taken, pred_target, flush, mispredict_cnt
  );
endinterface

// File: rtl/next_pc_btb.sv
// Next-PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Lookup and redirect are combinational; table and mispredict count update on posedge.
module next_pc_btb #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  next_pc_btb_if.slave  io_btb
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [15:0]      r_mis_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_hit;
  logic             w_ex_hit;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_ex_inc;
  logic             w_pred_taken;
  logic [PC_W-1:0]  w_pred_target;
  logic             w_flush;
  logic [PC_W-1:0]  w_pc_next;

  assign w_idx    = io_btb.pc[IDX_W-1:0];
  assign w_tag    = io_btb.pc[PC_W-1:IDX_W];
  assign w_ex_idx = io_btb.ex_pc[IDX_W-1:0];
  assign w_ex_tag = io_btb.ex_pc[PC_W-1:IDX_W];

  // Fetch lookup, flush decode and next-PC selection
  always_comb begin
    w_pc_inc      = io_btb.pc + PC_W'(1);
    w_ex_inc      = io_btb.ex_pc + PC_W'(1);
    w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    w_pred_taken  = w_hit && r_ctr[w_idx][1];
    w_pred_target = w_pc_inc;
    w_flush       = io_btb.ex_valid && io_btb.ex_mispredict;
    w_pc_next     = w_pc_inc;
    if (w_hit) begin
      w_pred_target = r_target[w_idx];
    end else begin
      w_pred_target = w_pc_inc;
    end
    // A redirect from EX outranks whatever fetch predicted this cycle
    if (w_flush) begin
      if (io_btb.ex_taken) begin
        w_pc_next = io_btb.ex_target;
      end else begin
        w_pc_next = w_ex_inc;
      end
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end else begin
      w_pc_next = w_pc_inc;
    end
  end

  // BTB training from resolved branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (io_btb.ex_valid && io_btb.ex_is_branch) begin
      if (w_ex_hit) begin
        if (io_btb.ex_taken) begin
          r_target[w_ex_idx] <= io_btb.ex_target;
          if (r_ctr[w_ex_idx] != 2'b11) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
          end
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
        end
      end else if (io_btb.ex_taken) begin
        // Allocation evicts whatever alias occupied the slot
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= io_btb.ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis_cnt <= 16'h0000;
    end else if (w_flush && (r_mis_cnt != 16'hFFFF)) begin
      r_mis_cnt <= r_mis_cnt + 16'h0001;
    end
  end

  assign io_btb.pc_next        = w_pc_next;
  assign io_btb.pred_taken     = w_pred_taken;
  assign io_btb.pred_target    = w_pred_target;
  assign io_btb.flush          = w_flush;
  assign io_btb.mispredict_cnt = r_mis_cnt;
endmodule

// File: tb/tb_next_pc_btb.sv
// Directed self-checking bench for next_pc_btb: allocation, counter decay,
// aliasing, flush priority, read-during-write, async reset and PC wrap.
module tb_next_pc_btb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  next_pc_btb_if #(.PC_W(16)) io ();

  next_pc_btb #(.PC_W(16), .IDX_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_btb (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    io.ex_valid      = 1'b0;
    io.ex_is_branch  = 1'b0;
    io.ex_pc         = 16'h0000;
    io.ex_taken      = 1'b0;
    io.ex_target     = 16'h0000;
    io.ex_mispredict = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic [15:0] epc, input logic tk,
                         input logic [15:0] tgt, input logic mp);
    io.ex_valid      = 1'b1;
    io.ex_is_branch  = br;
    io.ex_pc         = epc;
    io.ex_taken      = tk;
    io.ex_target     = tgt;
    io.ex_mispredict = mp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    io.pc = 16'h0000;
    #2;
    checks++; if (io.pc_next !== 16'h0001) begin errors++; $display("FAIL rst_pc_next: got %h expected %h", io.pc_next, 16'h0001); end
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken: got %b expected 0", io.pred_taken); end
    checks++; if (io.pred_target !== 16'h0001) begin errors++; $display("FAIL rst_pred_target: got %h expected %h", io.pred_target, 16'h0001); end
    checks++; if (io.flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b expected 0", io.flush); end
    checks++; if (io.mispredict_cnt !== 16'h0000) begin errors++; $display("FAIL rst_cnt: got %h expected %h", io.mispredict_cnt, 16'h0000); end
    io.pc = 16'hFFFF;
    #1;
    checks++; if (io.pc_next !== 16'h0000) begin errors++; $display("FAIL rst_wrap: got %h expected %h", io.pc_next, 16'h0000); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alloc();
    io.pc = 16'h0020;
    resolve(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1);
    #1;
    checks++; if (io.pc_next !== 16'h0040) begin errors++; $display("FAIL alloc_redirect: got %h expected %h", io.pc_next, 16'h0040); end
    checks++; if (io.flush !== 1'b1) begin errors++; $display("FAIL alloc_flush: got %b expected 1", io.flush); end
    tick();
    idle();
    io.pc = 16'h0010;
    #1;
    checks++; if (io.mispredict_cnt !== 16'h0001) begin errors++; $display("FAIL alloc_cnt: got %h expected %h", io.mispredict_cnt, 16'h0001); end
    checks++; if (io.flush !== 1'b0) begin errors++; $display("FAIL alloc_flush_clear: got %b expected 0", io.flush); end
    checks++; if (io.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %b expected 1", io.pred_taken); end
    checks++; if (io.pc_next !== 16'h0040) begin errors++; $display("FAIL alloc_pred_next: got %h expected %h", io.pc_next, 16'h0040); end
  endtask

  task automatic test_ctr_decay();
    io.pc = 16'h0033;
    resolve(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++; if (io.pc_next !== 16'h0034) begin errors++; $display("FAIL decay1_next: got %h expected %h", io.pc_next, 16'h0034); end
    tick();
    idle();
    io.pc = 16'h0010;
    #1;
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL decay1_pred: got %b expected 0", io.pred_taken); end
    resolve(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (io.pc_next !== 16'h0011) begin errors++; $display("FAIL decay2_redirect: got %h expected %h", io.pc_next, 16'h0011); end
    tick();
    idle();
    #1;
    checks++; if (io.mispredict_cnt !== 16'h0002) begin errors++; $display("FAIL decay2_cnt: got %h expected %h", io.mispredict_cnt, 16'h0002); end
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL decay2_pred: got %b expected 0", io.pred_taken); end
    checks++; if (io.pc_next !== 16'h0011) begin errors++; $display("FAIL decay2_next: got %h expected %h", io.pc_next, 16'h0011); end
    checks++; if (io.pred_target !== 16'h0040) begin errors++; $display("FAIL decay2_target: got %h expected %h", io.pred_target, 16'h0040); end
    // ctr is now 00: one taken step must only reach 01, still not predicted taken
    resolve(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL decay_floor: got %b expected 0", io.pred_taken); end
  endtask

  task automatic test_alias();
    io.pc = 16'h0018;
    #1;
    checks++; if (io.pc_next !== 16'h0019) begin errors++; $display("FAIL alias_miss_next: got %h expected %h", io.pc_next, 16'h0019); end
    checks++; if (io.pred_target !== 16'h0019) begin errors++; $display("FAIL alias_miss_target: got %h expected %h", io.pred_target, 16'h0019); end
    resolve(1'b1, 16'h0018, 1'b1, 16'h0080, 1'b1);
    #1;
    checks++; if (io.pc_next !== 16'h0080) begin errors++; $display("FAIL alias_redirect: got %h expected %h", io.pc_next, 16'h0080); end
    tick();
    idle();
    #1;
    checks++; if (io.pc_next !== 16'h0080) begin errors++; $display("FAIL alias_new_pred: got %h expected %h", io.pc_next, 16'h0080); end
    io.pc = 16'h0010;
    #1;
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_evicted: got %b expected 0", io.pred_taken); end
    checks++; if (io.pred_target !== 16'h0011) begin errors++; $display("FAIL alias_old_target: got %h expected %h", io.pred_target, 16'h0011); end
    // Non-branch mispredict flushes but must not touch the table
    io.pc = 16'h0040;
    resolve(1'b0, 16'h0018, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (io.flush !== 1'b1) begin errors++; $display("FAIL nonbr_flush: got %b expected 1", io.flush); end
    checks++; if (io.pc_next !== 16'h0019) begin errors++; $display("FAIL nonbr_next: got %h expected %h", io.pc_next, 16'h0019); end
    tick();
    idle();
    io.pc = 16'h0018;
    #1;
    checks++; if (io.pred_taken !== 1'b1) begin errors++; $display("FAIL nonbr_table_kept: got %b expected 1", io.pred_taken); end
    checks++; if (io.mispredict_cnt !== 16'h0004) begin errors++; $display("FAIL nonbr_cnt: got %h expected %h", io.mispredict_cnt, 16'h0004); end
  endtask

  task automatic test_same_cycle();
    io.pc = 16'h0033;
    resolve(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    tick();
    idle();
    io.pc = 16'h0010;
    resolve(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (io.pc_next !== 16'h0006) begin errors++; $display("FAIL same_flush_prio: got %h expected %h", io.pc_next, 16'h0006); end
    checks++; if (io.flush !== 1'b1) begin errors++; $display("FAIL same_flush: got %b expected 1", io.flush); end
    checks++; if (io.pred_taken !== 1'b1) begin errors++; $display("FAIL same_pred_driven: got %b expected 1", io.pred_taken); end
    checks++; if (io.pred_target !== 16'h0040) begin errors++; $display("FAIL same_pred_target: got %h expected %h", io.pred_target, 16'h0040); end
    tick();
    resolve(1'b1, 16'h0010, 1'b1, 16'h0050, 1'b0);
    #1;
    checks++; if (io.pc_next !== 16'h0040) begin errors++; $display("FAIL rdw_old: got %h expected %h", io.pc_next, 16'h0040); end
    tick();
    idle();
    #1;
    checks++; if (io.pc_next !== 16'h0050) begin errors++; $display("FAIL rdw_new: got %h expected %h", io.pc_next, 16'h0050); end
    checks++; if (io.mispredict_cnt !== 16'h0005) begin errors++; $display("FAIL rdw_cnt: got %h expected %h", io.mispredict_cnt, 16'h0005); end
  endtask

  task automatic test_async_reset();
    io.pc = 16'h0010;
    resolve(1'b1, 16'h0010, 1'b1, 16'h0070, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (io.mispredict_cnt !== 16'h0000) begin errors++; $display("FAIL arst_cnt: got %h expected %h", io.mispredict_cnt, 16'h0000); end
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL arst_pred: got %b expected 0", io.pred_taken); end
    checks++; if (io.pc_next !== 16'h0011) begin errors++; $display("FAIL arst_next: got %h expected %h", io.pc_next, 16'h0011); end
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    io.pc = 16'h0010;
    #1;
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL arst_after_0010: got %b expected 0", io.pred_taken); end
    io.pc = 16'h0018;
    #1;
    checks++; if (io.pred_taken !== 1'b0) begin errors++; $display("FAIL arst_after_0018: got %b expected 0", io.pred_taken); end
  endtask

  task automatic test_wrap();
    io.pc = 16'h1234;
    resolve(1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (io.pc_next !== 16'h0000) begin errors++; $display("FAIL wrap_ex: got %h expected %h", io.pc_next, 16'h0000); end
    tick();
    idle();
    #1;
    checks++; if (io.mispredict_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_cnt: got %h expected %h", io.mispredict_cnt, 16'h0001); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc();
    test_ctr_decay();
    test_alias();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/next_pc_btb.md
Name: next_pc_btb

Overview:
- Fetch-side next-PC generator. It sits directly upstream of the PC register and drives that register's pc_input every cycle.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters to predict taken branches at fetch.
- Takes branch resolution from EX, redirects fetch on a mispredict and raises flush to the IF/ID and ID/EX registers.
- Keeps a saturating mispredict counter for performance debug.

Parameters:
- PC_W, 16, PC and target width; word-addressed, sequential PC is pc+1.
- IDX_W, 3, index bits; ENTRIES = 2^IDX_W = 8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- pc  in  PC_W  current PC (the PC register's output).
- ex_valid  in  1  EX holds a resolved instruction this cycle; single-cycle per instruction, deasserted by EX while stalled.
- ex_is_branch  in  1  resolved instruction is a branch or jump.
- ex_pc  in  PC_W  PC of the resolved instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  PC_W  actual taken target.
- ex_mispredict  in  1  EX compared the actual outcome against the piped pred_taken/pred_target and found a mismatch.
- pc_next  out  PC_W  to the PC register's pc_input.
- pred_taken  out  1  fetch prediction; piped alongside the instruction.
- pred_target  out  PC_W  predicted target; piped alongside the instruction.
- flush  out  1  squash IF/ID and ID/EX.
- mispredict_cnt  out  16  saturating count of mispredicts.

Behaviour:
- Entry fields: valid, tag (PC_W-IDX_W bits), target (PC_W), ctr (2 bits).
- Index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W]. Same split applies to ex_pc.
- Lookup is combinational on pc: hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = entry target when hit, else pc+1.
- pc_next priority, combinational:
  1. flush -> ex_taken ? ex_target : ex_pc+1
  2. else pred_taken -> pred_target
  3. else pc+1
- flush = ex_valid && ex_mispredict. Same cycle as the EX result, zero latency. pred_taken is still driven during flush but is ignored downstream.
- All PC+1 arithmetic is modulo 2^PC_W: 0xFFFF+1 = 0x0000, no carry out.
- Table update at posedge when ex_valid && ex_is_branch, at index/tag from ex_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = ex_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any alias. valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no change.
- Read-during-write: if the fetch lookup and the update hit the same entry in the same cycle, the lookup sees the pre-update contents. The new contents are visible the next cycle.
- ex_valid with ex_is_branch=0: no table change. Flush still applies if ex_mispredict=1, e.g. a non-branch predicted taken because of aliasing.
- mispredict_cnt increments on each posedge with flush=1 and saturates at 0xFFFF.
- Stall and halt are not inputs. The PC register ignores pc_next while frozen; updates and flush are driven only by ex_valid.
- Reset (async, any time including mid-update):
  - All valid=0, all ctr=2'b01, all targets=0, mispredict_cnt=0.
  - Outputs then settle combinationally to pc_next=pc+1, pred_taken=0, pred_target=pc+1, flush=0 (with ex_valid held low).
  - No partial entry update survives reset.

Test Plan:
- Reset, pc=0x0000, ex_valid=0 -> pc_next=0x0001, pred_taken=0, flush=0, mispredict_cnt=0; pc=0xFFFF -> pc_next=0x0000.
- EX: ex_pc=0x0010 taken, target 0x0040, mispredict=1 -> same cycle pc_next=0x0040, flush=1; next cycle mispredict_cnt=1. Then pc=0x0010 -> pred_taken=1, pc_next=0x0040.
- Two not-taken resolves at 0x0010, no mispredict on the first, mispredict on the second -> ctr 10->01->00. pc=0x0010 then gives pred_taken=0, pc_next=0x0011.
- Alias: entry at 0x0010 valid, pc=0x0018 -> miss, pc_next=0x0019. Taken resolve at 0x0018 -> target 0x0080 replaces the entry; pc=0x0010 now misses.
- Same cycle: pc=0x0010 hits (target 0x0040) while EX flushes ex_pc=0x0005 not taken -> pc_next=0x0006, flush=1. Simultaneous update to pc's own entry -> lookup returns the old target that cycle, the new target the next cycle.
- Assert rst_n low mid-run with valid entries and mispredict_cnt=5 -> immediately all entries invalid and count 0. After release, pc=0x0010 -> pred_taken=0.
